// File: rtl/pool2d_engine.sv
// Parametrised K x K / stride S pooling engine (max or average) over a CHW feature map.
// Optional argmax capture and gradient routing are enabled with `define POOL_BACKPROP_EN.
module pool2d_engine #(
    parameter int DATA_W   = 16,
    parameter int FRAC     = 8,
    parameter int IN_W     = 64,
    parameter int IN_H     = 64,
    parameter int CHANNELS = 30,
    parameter int K        = 2,
    parameter int S        = 2,
    localparam int OUT_W   = (IN_W - K) / S + 1,
    localparam int OUT_H   = (IN_H - K) / S + 1,
    localparam int IA_W    = $clog2(IN_W * IN_H * CHANNELS),
    localparam int OA_W    = $clog2(OUT_W * OUT_H * CHANNELS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic              rd_en,
    output logic [IA_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [OA_W-1:0]   out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] grad_in,
    input  logic              grad_in_valid,
    output logic              grad_in_ready,
    output logic [DATA_W-1:0] grad_out,
    output logic [IA_W-1:0]   grad_out_addr,
    output logic              grad_out_valid,
    input  logic              bwd_start,
    output logic              bwd_done
);
    localparam int LOGK  = $clog2(K);
    localparam int ACC_W = DATA_W + 2 * LOGK;
    localparam int WI_W  = (K > 1) ? $clog2(K * K) : 1;
    localparam logic [31:0] K_LAST  = 32'(K - 1);
    localparam logic [31:0] OX_LAST = 32'(OUT_W - 1);
    localparam logic [31:0] OY_LAST = 32'(OUT_H - 1);
    localparam logic [31:0] C_LAST  = 32'(CHANNELS - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_EMIT, ST_BWD, ST_FIN} state_e;

    state_e                    state_q, state_d;
    logic                      pend_q, pend_d, mode_q, mode_d, bwd_q, bwd_d;
    logic [31:0]               kx_q, kx_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d, c_q, c_d;
    logic [31:0]               ox_n_s, oy_n_s, c_n_s;
    logic signed [DATA_W-1:0]  max_q, max_d, out_data_q, out_data_d, rd_s;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [WI_W-1:0]           arg_q, arg_d, wi_s;
    logic                      last_elem_s, last_win_s, rd_fire_s, gin_fire_s;
    logic                      unused_s;

    assign rd_s        = rd_data;
    assign wi_s        = WI_W'(ky_q * 32'(K) + kx_q);
    assign last_elem_s = (kx_q == K_LAST) && (ky_q == K_LAST);
    assign last_win_s  = (ox_q == OX_LAST) && (oy_q == OY_LAST) && (c_q == C_LAST);
    assign rd_fire_s   = (state_q == ST_FETCH) && pend_q && rd_valid;

    assign rd_en     = (state_q == ST_FETCH) && !pend_q;
    assign rd_addr   = IA_W'(c_q * 32'(IN_H * IN_W) + (oy_q * 32'(S) + ky_q) * 32'(IN_W)
                             + ox_q * 32'(S) + kx_q);
    assign out_addr  = OA_W'(c_q * 32'(OUT_H * OUT_W) + oy_q * 32'(OUT_W) + ox_q);
    assign out_valid = (state_q == ST_EMIT);
    assign out_data  = out_data_q;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_EMIT) || (state_q == ST_BWD);
    assign done      = (state_q == ST_FIN) && !bwd_q;

    // Scan position of the next window: ox fastest, then oy, then channel.
    always_comb begin
        ox_n_s = ox_q + 32'd1;
        oy_n_s = oy_q;
        c_n_s  = c_q;
        if (ox_q == OX_LAST) begin
            ox_n_s = 32'd0;
            if (oy_q == OY_LAST) begin
                oy_n_s = 32'd0;
                c_n_s  = c_q + 32'd1;
            end else begin
                oy_n_s = oy_q + 32'd1;
            end
        end else begin
            ox_n_s = ox_q + 32'd1;
        end
    end

    // Next-state, reduction and scan-counter logic.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        mode_d     = mode_q;
        bwd_d      = bwd_q;
        kx_d       = kx_q;
        ky_d       = ky_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        c_d        = c_q;
        max_d      = max_q;
        acc_d      = acc_q;
        arg_d      = arg_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                {kx_d, ky_d, ox_d, oy_d, c_d} = '0;
                pend_d = 1'b0;
                if (start) begin
                    state_d = ST_FETCH;
                    mode_d  = mode;
                    bwd_d   = 1'b0;
                end
`ifdef POOL_BACKPROP_EN
                else if (bwd_start) begin
                    state_d = ST_BWD;
                    bwd_d   = 1'b1;
                end
`endif
                else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (!pend_q) begin
                    pend_d = 1'b1;
                end else if (rd_valid) begin
                    pend_d = 1'b0;
                    // First element seeds; later ones win only on strict > so ties keep the first.
                    if (wi_s == '0) begin
                        max_d = rd_s;
                        arg_d = '0;
                        acc_d = ACC_W'(rd_s);
                    end else begin
                        acc_d = acc_q + ACC_W'(rd_s);
                        if (rd_s > max_q) begin
                            max_d = rd_s;
                            arg_d = wi_s;
                        end else begin
                            max_d = max_q;
                        end
                    end
                    if (last_elem_s) begin
                        kx_d       = 32'd0;
                        ky_d       = 32'd0;
                        state_d    = ST_EMIT;
                        out_data_d = mode_q ? DATA_W'(acc_d >>> (2 * LOGK)) : max_d;
                    end else if (kx_q == K_LAST) begin
                        kx_d = 32'd0;
                        ky_d = ky_q + 32'd1;
                    end else begin
                        kx_d = kx_q + 32'd1;
                    end
                end else begin
                    pend_d = 1'b1;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (last_win_s) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_FETCH;
                        ox_d    = ox_n_s;
                        oy_d    = oy_n_s;
                        c_d     = c_n_s;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_BWD: begin
                if (gin_fire_s) begin
                    if (last_win_s) begin
                        state_d = ST_FIN;
                    end else begin
                        ox_d = ox_n_s;
                        oy_d = oy_n_s;
                        c_d  = c_n_s;
                    end
                end else begin
                    state_d = ST_BWD;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pend_q     <= 1'b0;
            mode_q     <= 1'b0;
            bwd_q      <= 1'b0;
            {kx_q, ky_q, ox_q, oy_q, c_q} <= '0;
            max_q      <= '0;
            acc_q      <= '0;
            arg_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            mode_q     <= mode_d;
            bwd_q      <= bwd_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            c_q        <= c_d;
            max_q      <= max_d;
            acc_q      <= acc_d;
            arg_q      <= arg_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef POOL_BACKPROP_EN
    logic [WI_W-1:0]   am_ram [OUT_W*OUT_H*CHANNELS];
    logic [WI_W-1:0]   am_s;
    logic [DATA_W-1:0] grad_out_q;
    logic [IA_W-1:0]   grad_out_addr_q;
    logic              grad_out_valid_q;

    assign am_s           = am_ram[out_addr];
    assign gin_fire_s     = (state_q == ST_BWD) && grad_in_valid;
    assign grad_in_ready  = (state_q == ST_BWD);
    assign grad_out       = grad_out_q;
    assign grad_out_addr  = grad_out_addr_q;
    assign grad_out_valid = grad_out_valid_q;
    assign bwd_done       = (state_q == ST_FIN) && bwd_q;
    assign unused_s       = FRAC[0];

    // Argmax capture on the final element of each max-mode window; never cleared.
    always_ff @(posedge clk) begin
        if (!reset && rd_fire_s && last_elem_s && !mode_q) begin
            am_ram[out_addr] <= arg_d;
        end
    end

    // Route each accepted gradient to the stored argmax position of its window.
    always_ff @(posedge clk) begin
        if (reset) begin
            grad_out_q       <= '0;
            grad_out_addr_q  <= '0;
            grad_out_valid_q <= 1'b0;
        end else begin
            grad_out_valid_q <= gin_fire_s;
            if (gin_fire_s) begin
                grad_out_q      <= grad_in;
                grad_out_addr_q <= IA_W'(c_q * 32'(IN_H * IN_W)
                                   + (oy_q * 32'(S) + 32'(am_s) / 32'(K)) * 32'(IN_W)
                                   + ox_q * 32'(S) + 32'(am_s) % 32'(K));
            end else begin
                grad_out_q      <= grad_out_q;
                grad_out_addr_q <= grad_out_addr_q;
            end
        end
    end
`else
    assign gin_fire_s     = 1'b0;
    assign grad_in_ready  = 1'b0;
    assign grad_out       = '0;
    assign grad_out_addr  = '0;
    assign grad_out_valid = 1'b0;
    assign bwd_done       = 1'b0;
    assign unused_s       = ^{grad_in, grad_in_valid, bwd_start, FRAC[0]};
`endif

endmodule

// File: tb/tb_pool2d_engine.sv
// Directed bench for pool2d_engine: 4x4x1 K2/S2 and 4x4x2 K3/S1 instances with a latency-1 memory model.
module tb_pool2d_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, start_a, mode_a, rd_en_a, rd_valid_a, out_valid_a, out_ready_a, busy_a, done_a;
    logic        grad_in_valid_a, grad_in_ready_a, grad_out_valid_a, bwd_start_a, bwd_done_a;
    logic [3:0]  rd_addr_a, grad_out_addr_a;
    logic [1:0]  out_addr_a;
    logic [15:0] rd_data_a, out_data_a, grad_in_a, grad_out_a;

    logic        reset_b, start_b, rd_en_b, rd_valid_b, out_valid_b, busy_b, done_b;
    logic        grad_in_ready_b, grad_out_valid_b, bwd_done_b;
    logic [4:0]  rd_addr_b, grad_out_addr_b;
    logic [2:0]  out_addr_b;
    logic [15:0] rd_data_b, out_data_b, grad_out_b;

    logic [15:0] mem_a [16];
    logic [15:0] mem_b [32];
    int          exp_d [8];
    int          errors = 0;
    int          checks = 0;

    pool2d_engine #(.DATA_W(16), .FRAC(8), .IN_W(4), .IN_H(4), .CHANNELS(1), .K(2), .S(2)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .mode(mode_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .out_data(out_data_a), .out_addr(out_addr_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .busy(busy_a), .done(done_a), .grad_in(grad_in_a), .grad_in_valid(grad_in_valid_a),
        .grad_in_ready(grad_in_ready_a), .grad_out(grad_out_a), .grad_out_addr(grad_out_addr_a),
        .grad_out_valid(grad_out_valid_a), .bwd_start(bwd_start_a), .bwd_done(bwd_done_a));

    pool2d_engine #(.DATA_W(16), .FRAC(8), .IN_W(4), .IN_H(4), .CHANNELS(2), .K(3), .S(1)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .mode(1'b0),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .out_data(out_data_b), .out_addr(out_addr_b), .out_valid(out_valid_b), .out_ready(1'b1),
        .busy(busy_b), .done(done_b), .grad_in(16'd0), .grad_in_valid(1'b0),
        .grad_in_ready(grad_in_ready_b), .grad_out(grad_out_b), .grad_out_addr(grad_out_addr_b),
        .grad_out_valid(grad_out_valid_b), .bwd_start(1'b0), .bwd_done(bwd_done_b));

    // Single-cycle-latency activation buffers.
    always @(posedge clk) begin
        rd_valid_a <= rd_en_a;
        rd_data_a  <= mem_a[rd_addr_a];
        rd_valid_b <= rd_en_b;
        rd_data_b  <= mem_b[rd_addr_b];
    end

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start_a(input logic m);
        start_a = 1'b1;
        mode_a  = m;
        @(negedge clk);
        start_a = 1'b0;
        mode_a  = ~m;
        check_val("a_busy_start", busy_a, 1);
    endtask

    task automatic collect_a(input int first, input int nexp);
        int  idx = first;
        int  cyc = 0;
        bit  seen = 1'b0;
        while (!seen && cyc < 500) begin
            if (out_valid_a && out_ready_a) begin
                if (idx < 8) begin
                    check_val("a_data", $signed(out_data_a), exp_d[idx]);
                    check_val("a_addr", int'(out_addr_a), idx);
                end
                idx++;
            end
            if (done_a) begin
                seen = 1'b1;
                check_val("a_busy_at_done", busy_a, 0);
            end
            @(negedge clk);
            cyc++;
        end
        check_val("a_done_seen", seen, 1);
        check_val("a_out_count", idx, nexp);
        check_val("a_done_pulse", done_a, 0);
    endtask

    task automatic load_ramp_a();
        for (int i = 0; i < 16; i++) mem_a[i] = 16'(i);
    endtask

    initial begin
        int n;
        int cyc;
        int idx;
        bit seen;
        int gv [4];
        int ga [4];
        load_ramp_a();
        for (int i = 0; i < 32; i++) mem_b[i] = 16'(i);
        reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; mode_a = 1'b0; start_b = 1'b0;
        out_ready_a = 1'b1; grad_in_a = 16'd0; grad_in_valid_a = 1'b0; bwd_start_a = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy_a, 0);
        check_val("rst_rd_en", rd_en_a, 0);
        check_val("rst_out_valid", out_valid_a, 0);
        check_val("rst_done", done_a, 0);
        check_val("rst_out_data", int'(out_data_a), 0);
        reset_a = 1'b0; reset_b = 1'b0;
        @(negedge clk);

        // Max pool 2x2/2 over a 0..15 ramp.
        exp_d[0] = 5; exp_d[1] = 7; exp_d[2] = 13; exp_d[3] = 15;
        pulse_start_a(1'b0);
        collect_a(0, 4);

        // Average pool over the same ramp.
        exp_d[0] = 2; exp_d[1] = 4; exp_d[2] = 10; exp_d[3] = 12;
        pulse_start_a(1'b1);
        collect_a(0, 4);

        // Negative window averages round toward -inf.
        mem_a[0] = -16'sd1; mem_a[1] = -16'sd2; mem_a[4] = -16'sd3; mem_a[5] = -16'sd4;
        exp_d[0] = -3;
        pulse_start_a(1'b1);
        collect_a(0, 4);
        load_ramp_a();

        // Backpressure: first output held for 5 cycles with no reads issued.
        exp_d[0] = 5; exp_d[1] = 7; exp_d[2] = 13; exp_d[3] = 15;
        out_ready_a = 1'b0;
        pulse_start_a(1'b0);
        cyc = 0;
        while (!out_valid_a && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_val("stall_reached", out_valid_a, 1);
        for (int i = 0; i < 5; i++) begin
            check_val("stall_valid", out_valid_a, 1);
            check_val("stall_data", int'(out_data_a), 5);
            check_val("stall_addr", int'(out_addr_a), 0);
            check_val("stall_rd_en", rd_en_a, 0);
            @(negedge clk);
        end
        out_ready_a = 1'b1;
        collect_a(0, 4);

        // Reset during the 3rd read of window 2, then a clean rerun.
        pulse_start_a(1'b0);
        n = 0;
        cyc = 0;
        while (n < 7 && cyc < 100) begin
            if (rd_en_a) n++;
            if (n < 7) begin
                @(negedge clk);
                cyc++;
            end
        end
        check_val("abort_rd_cnt", n, 7);
        check_val("abort_rd_addr", int'(rd_addr_a), 6);
        reset_a = 1'b1;
        @(negedge clk);
        check_val("abort_busy", busy_a, 0);
        check_val("abort_rd_en", rd_en_a, 0);
        check_val("abort_out_valid", out_valid_a, 0);
        check_val("abort_done", done_a, 0);
        check_val("abort_out_data", int'(out_data_a), 0);
        check_val("abort_rd_addr0", int'(rd_addr_a), 0);
        reset_a = 1'b0;
        @(negedge clk);
        check_val("abort_idle", busy_a, 0);
        pulse_start_a(1'b0);
        collect_a(0, 4);

        // K=3, S=1 over two channels.
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        exp_d[0] = 10; exp_d[1] = 11; exp_d[2] = 14; exp_d[3] = 15;
        exp_d[4] = 26; exp_d[5] = 27; exp_d[6] = 30; exp_d[7] = 31;
        idx = 0;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 1000) begin
            if (out_valid_b) begin
                if (idx < 8) begin
                    check_val("b_data", $signed(out_data_b), exp_d[idx]);
                    check_val("b_addr", int'(out_addr_b), idx);
                end
                idx++;
            end
            if (done_b) seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check_val("b_done_seen", seen, 1);
        check_val("b_out_count", idx, 8);

`ifdef POOL_BACKPROP_EN
        // Forward max run stores argmax wi = 3,0,1,2; gradients go to 5,2,9,14.
        for (int i = 0; i < 16; i++) mem_a[i] = 16'd0;
        mem_a[5] = 16'd9; mem_a[2] = 16'd9; mem_a[9] = 16'd9; mem_a[14] = 16'd9;
        for (int i = 0; i < 4; i++) exp_d[i] = 9;
        pulse_start_a(1'b0);
        collect_a(0, 4);
        gv[0] = 100; gv[1] = 200; gv[2] = 300; gv[3] = 400;
        ga[0] = 5;   ga[1] = 2;   ga[2] = 9;   ga[3] = 14;
        bwd_start_a = 1'b1;
        @(negedge clk);
        bwd_start_a = 1'b0;
        check_val("bwd_ready", grad_in_ready_a, 1);
        check_val("bwd_busy", busy_a, 1);
        for (int i = 0; i < 4; i++) begin
            grad_in_a       = 16'(gv[i]);
            grad_in_valid_a = 1'b1;
            @(negedge clk);
            grad_in_valid_a = 1'b0;
            check_val("bwd_gvalid", grad_out_valid_a, 1);
            check_val("bwd_gdata", int'(grad_out_a), gv[i]);
            check_val("bwd_gaddr", int'(grad_out_addr_a), ga[i]);
            check_val("bwd_done_flag", bwd_done_a, (i == 3) ? 1 : 0);
        end
        @(negedge clk);
        check_val("bwd_done_pulse", bwd_done_a, 0);
        check_val("bwd_idle", busy_a, 0);
        check_val("bwd_gvalid_pulse", grad_out_valid_a, 0);
`else
        // Without backprop the gradient side is inert and bwd_start is ignored.
        bwd_start_a     = 1'b1;
        grad_in_valid_a = 1'b1;
        @(negedge clk);
        bwd_start_a     = 1'b0;
        check_val("nobwd_busy", busy_a, 0);
        check_val("nobwd_ready", grad_in_ready_a, 0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bwd_done_a || grad_out_valid_a) seen = 1'b1;
            @(negedge clk);
        end
        grad_in_valid_a = 1'b0;
        check_val("nobwd_quiet", seen, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
